// File: rtl/writeusb_fifo_if.sv
// writeusb_fifo_if: user push port plus FT232H sync-FIFO transmit pins.
// slave is the FIFO side, master drives words and TXE#.
interface writeusb_fifo_if;
  logic [31:0] in32;
  logic        in_valid;
  logic        in_ready;
  logic        txe_n;
  logic [7:0]  dout;
  logic        dout_oe;
  logic        wr_n;
  logic        rd_n;
  logic        oe_n;
  logic        si_n;

  modport master (
    output in32, in_valid, txe_n,
    input  in_ready, dout, dout_oe,
    input  wr_n, rd_n, oe_n, si_n
  );

  modport slave (
    input  in32, in_valid, txe_n,
    output in_ready, dout, dout_oe,
    output wr_n, rd_n, oe_n, si_n
  );
endinterface

// File: rtl/writeusb_fifo.sv
// writeusb_fifo: buffers 32-bit words and streams them to an FT232H
// one byte per clkusb, with an idle-timeout SI/WUA# flush pulse.
module writeusb_fifo #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 64,
  parameter bit LSB_FIRST    = 1'b1
) (
  input  logic                     clkusb,
  input  logic                     rst,
  writeusb_fifo_if.slave           bus,
  output logic [31:0]              bytes_sent,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW =
    (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    PULSE
  } flush_e;

  logic [31:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [31:0] hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] bytes_q, bytes_d;
  logic        oe_q, oe_d;
  flush_e      st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        full, empty;
  logic        push, pop;
  logic        accept, last;
  logic        idle;
  logic [1:0]  sel;

  assign level  = wptr_q - rptr_q;
  assign full   = (level == (AW+1)'(DEPTH));
  assign empty  = (level == '0);

  assign bus.in_ready = !full && !rst;
  assign push   = bus.in_valid && bus.in_ready;
  assign accept = hold_valid_q && !bus.txe_n;
  assign last   = accept && (idx_q == 2'd3);
  // Refill on the last byte's edge keeps the stream gap-free.
  assign pop    = !empty && (!hold_valid_q || last);
  assign idle   = !hold_valid_q && empty;

  assign sel      = LSB_FIRST ? idx_q : ~idx_q;
  assign bus.dout = hold_valid_q ? hold_q[{sel, 3'b000} +: 8]
                                 : 8'h00;
  assign bus.wr_n    = !accept;
  assign bus.rd_n    = 1'b1;
  assign bus.oe_n    = 1'b1;
  assign bus.si_n    = (st_q != PULSE);
  assign bus.dout_oe = oe_q;
  assign bytes_sent  = bytes_q;

  always_comb begin
    wptr_d       = wptr_q + (AW+1)'(push);
    rptr_d       = rptr_q + (AW+1)'(pop);
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    idx_d        = idx_q;
    bytes_d      = bytes_q + {31'b0, accept};
    oe_d         = 1'b1;
    if (accept) begin
      idx_d = idx_q + 2'd1;
      if (last) hold_valid_d = 1'b0;
    end
    if (pop) begin
      hold_d       = mem_q[rptr_q[AW-1:0]];
      hold_valid_d = 1'b1;
      idx_d        = 2'd0;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      IDLE: begin
        cnt_d = '0;
        if (accept && FLUSH_CYCLES != 0) st_d = ARMED;
      end
      ARMED: begin
        if (accept || push)
          cnt_d = '0;
        else if (idle && cnt_q != CW'(FLUSH_CYCLES))
          cnt_d = cnt_q + CW'(1);
        if (cnt_d == CW'(FLUSH_CYCLES) && !bus.txe_n)
          st_d = PULSE;
      end
      PULSE: begin
        cnt_d = '0;
        st_d  = IDLE;
      end
      default: begin
        cnt_d = '0;
        st_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkusb) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= bus.in32;
  end

  always_ff @(posedge clkusb or posedge rst) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      idx_q        <= 2'd0;
      bytes_q      <= '0;
      oe_q         <= 1'b0;
      st_q         <= IDLE;
      cnt_q        <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      idx_q        <= idx_d;
      bytes_q      <= bytes_d;
      oe_q         <= oe_d;
      st_q         <= st_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_writeusb_fifo.sv
// tb_writeusb_fifo: directed vector table plus hand sequences for
// stall, full FIFO, flush pulse and mid-word reset.
module tb_writeusb_fifo;

  logic        clk;
  logic        rst;
  logic [31:0] bytes_sent;
  logic [2:0]  level;

  writeusb_fifo_if bus();

  writeusb_fifo #(
    .DEPTH(4),
    .FLUSH_CYCLES(8),
    .LSB_FIRST(1'b1)
  ) dut (
    .clkusb(clk),
    .rst(rst),
    .bus(bus.slave),
    .bytes_sent(bytes_sent),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] d;
    logic        txe;
    logic        wr_n;
    logic [7:0]  dout;
    logic [2:0]  lvl;
    logic [31:0] bs;
  } vec_t;

  vec_t tv[$];
  int   nvec;
  int   nbad;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic v, logic [31:0] d, logic t,
                              logic w, logic [7:0] o,
                              logic [2:0] l, logic [31:0] b);
    vec_t r;
    r.vld = v; r.d = d; r.txe = t;
    r.wr_n = w; r.dout = o; r.lvl = l; r.bs = b;
    return r;
  endfunction

  logic [7:0] got[$];
  int last_k, npulse, pk, stale;

  initial begin
    nvec = 0;
    nbad = 0;

    // single word, 2-cycle latency
    tv.push_back(mk(1, 32'h44332211, 0, 1, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 8'h11, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 8'h22, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 8'h33, 0, 2));
    tv.push_back(mk(0, 0, 0, 0, 8'h44, 0, 3));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 0, 4));
    // back-to-back words, no bubble
    tv.push_back(mk(1, 32'hA0A1A2A3, 0, 1, 8'h00, 0, 4));
    tv.push_back(mk(1, 32'hB0B1B2B3, 0, 1, 8'h00, 1, 4));
    tv.push_back(mk(0, 0, 0, 0, 8'hA3, 1, 4));
    tv.push_back(mk(0, 0, 0, 0, 8'hA2, 1, 5));
    tv.push_back(mk(0, 0, 0, 0, 8'hA1, 1, 6));
    tv.push_back(mk(0, 0, 0, 0, 8'hA0, 1, 7));
    tv.push_back(mk(0, 0, 0, 0, 8'hB3, 0, 8));
    tv.push_back(mk(0, 0, 0, 0, 8'hB2, 0, 9));
    tv.push_back(mk(0, 0, 0, 0, 8'hB1, 0, 10));
    tv.push_back(mk(0, 0, 0, 0, 8'hB0, 0, 11));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 0, 12));
    // mid-word TXE# stall
    tv.push_back(mk(1, 32'h0D0C0B0A, 0, 1, 8'h00, 0, 12));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 1, 12));
    tv.push_back(mk(0, 0, 0, 0, 8'h0A, 0, 12));
    tv.push_back(mk(0, 0, 0, 0, 8'h0B, 0, 13));
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(0, 0, 1, 1, 8'h0C, 0, 14));
    tv.push_back(mk(0, 0, 0, 0, 8'h0C, 0, 14));
    tv.push_back(mk(0, 0, 0, 0, 8'h0D, 0, 15));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 0, 16));

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in32 = '0;
    bus.txe_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst wr_n", 32'(bus.wr_n), 1);
    chk("rst si_n", 32'(bus.si_n), 1);
    chk("rst rd_n", 32'(bus.rd_n), 1);
    chk("rst oe_n", 32'(bus.oe_n), 1);
    chk("rst dout", 32'(bus.dout), 0);
    chk("rst dout_oe", 32'(bus.dout_oe), 0);
    chk("rst bytes", bytes_sent, 0);
    chk("rst level", 32'(level), 0);
    chk("rst in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("oe before edge", 32'(bus.dout_oe), 0);
    @(posedge clk);
    #1;
    chk("oe after edge", 32'(bus.dout_oe), 1);

    foreach (tv[i]) begin
      @(negedge clk);
      bus.in_valid = tv[i].vld;
      bus.in32     = tv[i].d;
      bus.txe_n    = tv[i].txe;
      #1;
      chk($sformatf("v%0d wr_n", i), 32'(bus.wr_n), 32'(tv[i].wr_n));
      chk($sformatf("v%0d dout", i), 32'(bus.dout), 32'(tv[i].dout));
      chk($sformatf("v%0d level", i), 32'(level), 32'(tv[i].lvl));
      chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 1);
      chk($sformatf("v%0d bytes", i), bytes_sent, tv[i].bs);
    end

    // fill under TXE# high: hold takes one word, FIFO takes DEPTH
    for (int w = 0; w < 5; w++) begin
      @(negedge clk);
      bus.txe_n    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in32     = 32'h03020100 + 32'h04040404 * w;
      #1;
      chk($sformatf("fill%0d in_ready", w), 32'(bus.in_ready), 1);
    end
    @(negedge clk);
    bus.in32 = 32'hDEADBEEF;
    #1;
    chk("full in_ready", 32'(bus.in_ready), 0);
    chk("full level", 32'(level), 4);
    chk("full wr_n", 32'(bus.wr_n), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.txe_n = 1'b0;
    got.delete();
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!bus.wr_n) got.push_back(bus.dout);
      @(negedge clk);
    end
    chk("drain count", 32'(got.size()), 20);
    foreach (got[i])
      if (i < 20) chk($sformatf("drain b%0d", i), 32'(got[i]), i);
    chk("drain bytes", bytes_sent, 36);
    chk("drain level", 32'(level), 0);

    // one word then idle: single SI# pulse 8 cycles after last byte
    last_k = -1;
    npulse = 0;
    pk = -1;
    for (int k = 0; k < 40; k++) begin
      bus.in_valid = (k == 0);
      bus.in32 = 32'hCAFEF00D;
      #1;
      if (!bus.wr_n) last_k = k;
      if (!bus.si_n) begin
        npulse++;
        pk = k;
      end
      @(negedge clk);
    end
    chk("flush last byte", 32'(last_k), 5);
    chk("flush pulses", 32'(npulse), 1);
    chk("flush when", 32'(pk), 32'(last_k + 9));
    chk("flush bytes", bytes_sent, 40);

    // reset after byte 1 of a word with two words queued
    bus.txe_n = 1'b1;
    for (int w = 0; w < 3; w++) begin
      bus.in_valid = 1'b1;
      bus.in32 = 32'h23222120 + 32'h04040404 * w;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.txe_n = 1'b0;
    #1;
    chk("pre level", 32'(level), 2);
    chk("pre b0", 32'(bus.dout), 32'h20);
    @(negedge clk);
    #1;
    chk("pre b1", 32'(bus.dout), 32'h21);
    @(negedge clk);
    #1;
    chk("pre b2", 32'(bus.dout), 32'h22);
    chk("pre wr_n", 32'(bus.wr_n), 0);
    chk("pre bytes", bytes_sent, 42);
    #1;
    rst = 1'b1;
    #1;
    chk("async wr_n", 32'(bus.wr_n), 1);
    chk("async level", 32'(level), 0);
    chk("async bytes", bytes_sent, 0);
    chk("async dout", 32'(bus.dout), 0);
    chk("async oe", 32'(bus.dout_oe), 0);
    chk("async in_ready", 32'(bus.in_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (!bus.wr_n) stale++;
    end
    chk("post stale bytes", 32'(stale), 0);
    chk("post oe", 32'(bus.dout_oe), 1);
    chk("post bytes", bytes_sent, 0);
    chk("post level", 32'(level), 0);
    chk("post in_ready", 32'(bus.in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
